// File: rtl/warblade_pkg.sv
// Shared constants and slot state type for the Warblade enemy missile logic.
package warblade_pkg;

    localparam int unsigned COORD_W = 11;
    localparam int unsigned SCREEN_H = 768;
    localparam logic [COORD_W-1:0] PARK_X = 11'd0;
    localparam logic [COORD_W-1:0] PARK_Y = 11'h7FF;
    localparam int unsigned EN_MISSILE_NUM = 5;

    typedef enum logic {SlotIdle, SlotFlying} slot_state_e;

endpackage

// File: rtl/enemy_missile_slot.sv
// One enemy missile: loads launch coordinates, falls SPEED pixels per tick,
// and parks itself once y reaches Y_LIMIT.
module enemy_missile_slot
    import warblade_pkg::*;
#(
    parameter int unsigned SPEED   = 4,
    parameter int unsigned Y_LIMIT = SCREEN_H
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic               tick_i,
    input  logic [COORD_W-1:0] load_x_i,
    input  logic [COORD_W-1:0] load_y_i,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic               flying_o
);

    localparam logic [COORD_W:0] SpeedExt = (COORD_W + 1)'(SPEED);

    slot_state_e        state_q;
    logic [COORD_W-1:0] x_q;
    logic [COORD_W-1:0] y_q;
    logic [COORD_W:0]   y_sum;

    // 12-bit sum so a missile near the bottom cannot wrap back to the top.
    assign y_sum = {1'b0, y_q} + SpeedExt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SlotIdle;
            x_q     <= PARK_X;
            y_q     <= PARK_Y;
        end else begin
            case (state_q)
                SlotIdle: begin
                    if (load_i) begin
                        state_q <= SlotFlying;
                        x_q     <= load_x_i;
                        y_q     <= load_y_i;
                    end
                end
                SlotFlying: begin
                    if (tick_i) begin
                        if (32'(y_sum) >= Y_LIMIT) begin
                            state_q <= SlotIdle;
                            x_q     <= PARK_X;
                            y_q     <= PARK_Y;
                        end else begin
                            y_q <= y_sum[COORD_W-1:0];
                        end
                    end
                end
                default: state_q <= SlotIdle;
            endcase
        end
    end

    assign x_o      = x_q;
    assign y_o      = y_q;
    assign flying_o = (state_q == SlotFlying);

endmodule

// File: rtl/enemy_missile_ctl.sv
// Enemy missile controller: five slots, lowest-idle launch selection, launch
// cooldown and drop pulse. Define ENEMY_MISSILE_FREEZE_EN to honour freeze.
module enemy_missile_ctl
    import warblade_pkg::*;
#(
    parameter int unsigned SPEED    = 4,
    parameter int unsigned Y_LIMIT  = SCREEN_H,
    parameter int unsigned COOLDOWN = 8
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               fire_req,
    input  logic [COORD_W-1:0] fire_x,
    input  logic [COORD_W-1:0] fire_y,
    input  logic               freeze,
    output logic [COORD_W-1:0] en_x_missile1,
    output logic [COORD_W-1:0] en_x_missile2,
    output logic [COORD_W-1:0] en_x_missile3,
    output logic [COORD_W-1:0] en_x_missile4,
    output logic [COORD_W-1:0] en_x_missile5,
    output logic [COORD_W-1:0] en_y_missile1,
    output logic [COORD_W-1:0] en_y_missile2,
    output logic [COORD_W-1:0] en_y_missile3,
    output logic [COORD_W-1:0] en_y_missile4,
    output logic [COORD_W-1:0] en_y_missile5,
    output logic [EN_MISSILE_NUM-1:0] active,
    output logic               drop
);

    localparam int unsigned CdW = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

    logic                      tick_en;
    logic                      fire_en;
    logic [EN_MISSILE_NUM-1:0] flying;
    logic [EN_MISSILE_NUM-1:0] load;
    logic [COORD_W-1:0]        slot_x [EN_MISSILE_NUM];
    logic [COORD_W-1:0]        slot_y [EN_MISSILE_NUM];
    logic [CdW-1:0]            cd_q, cd_d;
    logic                      drop_q, drop_d;
    logic                      fire_ok;
    logic                      found;

`ifdef ENEMY_MISSILE_FREEZE_EN
    assign tick_en = frame_tick & ~freeze;
    assign fire_en = fire_req & ~freeze;
`else
    logic unused_freeze;
    assign unused_freeze = freeze;
    assign tick_en       = frame_tick;
    assign fire_en       = fire_req;
`endif

    // Selection uses the current flying flags, so a slot retiring this cycle
    // only becomes loadable on the next one.
    always_comb begin
        fire_ok = fire_en && (cd_q == '0);
        load    = '0;
        found   = 1'b0;
        for (int i = 0; i < int'(EN_MISSILE_NUM); i++) begin
            if (fire_ok && !flying[i] && !found) begin
                load[i] = 1'b1;
                found   = 1'b1;
            end
        end
        drop_d = fire_ok && (&flying);
        cd_d   = cd_q;
        if (found) begin
            cd_d = CdW'(COOLDOWN);
        end else if (tick_en && (cd_q != '0)) begin
            cd_d = cd_q - CdW'(1);
        end
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            cd_q   <= '0;
            drop_q <= 1'b0;
        end else begin
            cd_q   <= cd_d;
            drop_q <= drop_d;
        end
    end

    for (genvar g = 0; g < EN_MISSILE_NUM; g++) begin : gen_slot
        enemy_missile_slot #(
            .SPEED   (SPEED),
            .Y_LIMIT (Y_LIMIT)
        ) u_slot (
            .clk_i    (pclk),
            .rst_ni   (rst),
            .load_i   (load[g]),
            .tick_i   (tick_en),
            .load_x_i (fire_x),
            .load_y_i (fire_y),
            .x_o      (slot_x[g]),
            .y_o      (slot_y[g]),
            .flying_o (flying[g])
        );
    end

    assign active        = flying;
    assign drop          = drop_q;
    assign en_x_missile1 = slot_x[0];
    assign en_x_missile2 = slot_x[1];
    assign en_x_missile3 = slot_x[2];
    assign en_x_missile4 = slot_x[3];
    assign en_x_missile5 = slot_x[4];
    assign en_y_missile1 = slot_y[0];
    assign en_y_missile2 = slot_y[1];
    assign en_y_missile3 = slot_y[2];
    assign en_y_missile4 = slot_y[3];
    assign en_y_missile5 = slot_y[4];

endmodule

// File: tb/tb_enemy_missile_ctl.sv
// Directed bench for enemy_missile_ctl with default parameters (SPEED 4, limit 768, cooldown 8).
module tb_enemy_missile_ctl;

    logic        pclk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_tick = 1'b0;
    logic        fire_req = 1'b0;
    logic [10:0] fire_x = '0;
    logic [10:0] fire_y = '0;
    logic        freeze = 1'b0;
    logic [10:0] x1, x2, x3, x4, x5;
    logic [10:0] y1, y2, y3, y4, y5;
    logic [4:0]  active;
    logic        drop;

    int tests = 0;
    int fails = 0;

    enemy_missile_ctl dut (
        .pclk          (pclk),
        .rst           (rst),
        .frame_tick    (frame_tick),
        .fire_req      (fire_req),
        .fire_x        (fire_x),
        .fire_y        (fire_y),
        .freeze        (freeze),
        .en_x_missile1 (x1),
        .en_x_missile2 (x2),
        .en_x_missile3 (x3),
        .en_x_missile4 (x4),
        .en_x_missile5 (x5),
        .en_y_missile1 (y1),
        .en_y_missile2 (y2),
        .en_y_missile3 (y3),
        .en_y_missile4 (y4),
        .en_y_missile5 (y5),
        .active        (active),
        .drop          (drop)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic fire(input logic [10:0] fx, input logic [10:0] fy);
        fire_req = 1'b1;
        fire_x   = fx;
        fire_y   = fy;
        step();
        fire_req = 1'b0;
    endtask

    task automatic ftick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) ftick();
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        #3;
        rst = 1'b1;
        step();
    endtask

    initial begin
        // Reset state
        step();
        step();
        check("rst_active", active, 5'b00000);
        check("rst_drop", drop, 0);
        check("rst_x1", x1, 0);
        check("rst_y1", y1, 11'h7FF);
        check("rst_y5", y5, 11'h7FF);
        rst = 1'b1;
        step();

        // First launch accepted, one-cycle latency
        fire(11'd100, 11'd50);
        check("l1_x1", x1, 100);
        check("l1_y1", y1, 50);
        check("l1_active", active, 5'b00001);
        check("l1_y2_park", y2, 11'h7FF);
        check("l1_x2_park", x2, 0);

        // Fire during cooldown is ignored silently
        ticks(2);
        check("cd_y1", y1, 58);
        fire(11'd200, 11'd60);
        check("cd_active", active, 5'b00001);
        check("cd_drop", drop, 0);
        check("cd_y2_park", y2, 11'h7FF);

        // Asynchronous reset mid-flight
        #2;
        rst = 1'b0;
        #1;
        check("async_active", active, 5'b00000);
        check("async_y1", y1, 11'h7FF);
        #1;
        rst = 1'b1;
        step();

        // Fall from 750 and retire at 770
        fire(11'd100, 11'd750);
        check("fall_y0", y1, 750);
        ftick(); check("fall_y1", y1, 754);
        ftick(); check("fall_y2", y1, 758);
        ftick(); check("fall_y3", y1, 762);
        ftick(); check("fall_y4", y1, 766);
        ftick();
        check("fall_park_y", y1, 11'h7FF);
        check("fall_park_x", x1, 0);
        check("fall_active", active, 5'b00000);

        // Five launches then a drop with all slots busy
        reset_dut();
        fire(11'd10, 11'd0); ticks(8);
        fire(11'd20, 11'd0); ticks(8);
        fire(11'd30, 11'd0); ticks(8);
        fire(11'd40, 11'd0); ticks(8);
        fire(11'd50, 11'd0);
        check("full_active", active, 5'b11111);
        check("full_drop0", drop, 0);
        ticks(8);
        check("full_y1", y1, 160);
        check("full_x5", x5, 50);
        check("full_y5", y5, 32);
        fire(11'd60, 11'd0);
        check("drop_pulse", drop, 1);
        check("drop_active", active, 5'b11111);
        step();
        check("drop_clear", drop, 0);
        fire(11'd60, 11'd0);
        check("drop_cd_zero", drop, 1);
        step();

        // Coincident fire and tick while slot 1 retires
        reset_dut();
        fire(11'd100, 11'd732);
        ticks(8);
        check("co_y1_pre", y1, 764);
        frame_tick = 1'b1;
        fire_req   = 1'b1;
        fire_x     = 11'd300;
        fire_y     = 11'd100;
        step();
        frame_tick = 1'b0;
        fire_req   = 1'b0;
        check("co_active", active, 5'b00010);
        check("co_x2", x2, 300);
        check("co_y2", y2, 100);
        check("co_y1_park", y1, 11'h7FF);
        check("co_drop", drop, 0);
        // Cooldown reload won over the coincident tick
        ticks(7);
        fire(11'd400, 11'd200);
        check("co_cd_hold", active, 5'b00010);
        check("co_y2_move", y2, 128);
        ftick();
        fire(11'd400, 11'd200);
        check("co_reuse_active", active, 5'b00011);
        check("co_reuse_x1", x1, 400);
        check("co_reuse_y1", y1, 200);

        // Freeze with three missiles flying
        reset_dut();
        fire(11'd10, 11'd100); ticks(8);
        fire(11'd20, 11'd100); ticks(8);
        fire(11'd30, 11'd100);
        check("fz_active", active, 5'b00111);
        freeze = 1'b1;
        ticks(10);
        freeze = 1'b0;
`ifdef ENEMY_MISSILE_FREEZE_EN
        check("fz_y1", y1, 164);
        check("fz_y2", y2, 132);
        check("fz_y3", y3, 100);
        ticks(7);
        fire(11'd40, 11'd100);
        check("fz_cd_kept", active, 5'b00111);
        ftick();
        fire(11'd40, 11'd100);
        check("fz_after", active, 5'b01111);
`else
        check("fz_y1", y1, 204);
        check("fz_y2", y2, 172);
        check("fz_y3", y3, 140);
        fire(11'd40, 11'd100);
        check("fz_after", active, 5'b01111);
`endif
        check("fz_x4", x4, 40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/enemy_missile_ctl.md
ENEMY_MISSILE_CTL -- requirements
Module: enemy_missile_ctl

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter SPEED, default 4: pixels added to missile y per frame tick.
REQ-003 Parameter Y_LIMIT, default 768: first y at or beyond which a missile retires.
REQ-004 Parameter COOLDOWN, default 8: minimum frame ticks between accepted launches.
REQ-005 pclk  input  1  pixel clock; all state on its rising edge.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 frame_tick  input  1  one-cycle pulse per frame; advances motion and cooldown.
REQ-008 fire_req  input  1  one-cycle launch request from the enemy formation.
REQ-009 fire_x, fire_y  input  11 each  launch coordinates, sampled with fire_req.
REQ-010 freeze  input  1  hold all missiles; honoured only per REQ-026.
REQ-011 en_x_missile1..en_x_missile5  output  11 each  missile x; feeds ship collision and drawing.
REQ-012 en_y_missile1..en_y_missile5  output  11 each  missile y.
REQ-013 active  output  5  bit k-1 high while slot k is flying.
REQ-014 drop  output  1  one-cycle pulse when an accepted-eligible fire_req finds no idle slot.

Function
REQ-015 Each slot SHALL be in state IDLE or FLYING; an IDLE slot SHALL drive x=0, y=11'h7FF (park).
REQ-016 fire_req with cooldown=0 SHALL load the lowest-index IDLE slot with fire_x/fire_y, visible on outputs the next cycle (latency 1), and set cooldown=COOLDOWN.
REQ-017 fire_req with cooldown>0 SHALL be ignored silently (no load, no drop).
REQ-018 fire_req with cooldown=0 and all five slots FLYING SHALL pulse drop the next cycle and leave cooldown at 0.
REQ-019 On frame_tick, each FLYING slot SHALL compute y+SPEED in 12 bits; if the sum is at or beyond Y_LIMIT, the slot SHALL go IDLE and park; otherwise y SHALL take the sum; x SHALL be unchanged.
REQ-020 On frame_tick, cooldown SHALL decrement if nonzero and saturate at 0.
REQ-021 When frame_tick and fire_req coincide, the freshly loaded slot SHALL NOT move that cycle; a slot retiring that cycle SHALL NOT be eligible for loading until the next cycle.
REQ-022 The cooldown load of REQ-016 SHALL take priority over a coincident decrement.
REQ-023 All outputs SHALL be registered; no combinational path from input to output.

Reset
REQ-024 Asserting rst SHALL immediately force all slots IDLE and parked, active=0, drop=0, cooldown=0, including mid-flight.
REQ-025 The first fire_req after reset release SHALL be accepted (cooldown=0).

Configuration
REQ-026 With ENEMY_MISSILE_FREEZE_EN defined: while freeze=1, frame_tick SHALL not move missiles or decrement cooldown, and fire_req SHALL be ignored without drop; state SHALL be kept. Without the macro, freeze SHALL be ignored.

Structure
REQ-027 Package warblade_pkg SHALL hold SCREEN_H=768, PARK_X=0, PARK_Y=11'h7FF, EN_MISSILE_NUM=5, and the slot state enum.
REQ-028 The design SHALL use one sub-module, enemy_missile_slot, instantiated five times with the load enable, tick, x/y registers and retirement logic; the top SHALL hold the priority selection, the cooldown counter and the drop pulse.

Verification
REQ-029 Reset, then fire_req at x=100, y=50 -> next cycle en_x_missile1=100, en_y_missile1=50, active=00001; slots 2-5 remain parked.
REQ-030 Fly slot 1 from y=750 with SPEED=4 -> y=754, 758, 762, 766 over four ticks; on the fifth tick the sum 770 is at or beyond 768, so the slot parks at 0/7FF and active bit 0 clears.
REQ-031 Issue five launches spaced 8 ticks apart, then a sixth with cooldown=0 -> drop pulses for one cycle and active stays 11111.
REQ-032 Issue fire_req two ticks after an accepted launch -> ignored, drop=0, active unchanged.
REQ-033 Drive fire_req and frame_tick in the same cycle while slot 1 retires -> slot 2 loads unmoved, and slot 1 parks.
REQ-034 With the macro defined, hold freeze=1 for 10 ticks while 3 missiles fly -> positions and cooldown are unchanged; with the macro undefined -> missiles advance 40 pixels.
